lea_block_loader: RTL
=====================

// Module: lea_block_loader
// PURPOSE
// Downstream of the keypad/plaintext-entry stage. Snapshots the 16 entered plaintext bytes when '#' is pressed,
// packs them into LEA little-endian 32-bit words and offers the block to the LEA core over a valid/ready handshake.
// Waits for the ciphertext, unpacks it back into 16 display bytes for the LCD line-2 driver, and guards with a timeout.
// PARAMETERS
// SYNC_STAGES  2      synchroniser depth on SHARP/STAR key levels (>=2)
// TIMEOUT      4096   max CLK cycles in WAIT_CT before ERR (1..65535)
// PORTS
// CLK        in   1    system clock, all logic on rising edge
// RST        in   1    asynchronous, active-low reset
// PT_BYTES   in   128  plaintext bytes; byte1 (first keyed) = [127:120] ... byte16 = [7:0]
// SHARP      in   1    raw '#' key level (asynchronous to CLK): start encryption
// STAR       in   1    raw '*' key level (asynchronous to CLK): abort/clear
// BLK_DATA   out  128  {W3,W2,W1,W0}; Wi = {byte(4i+4),byte(4i+3),byte(4i+2),byte(4i+1)}
// BLK_VALID  out  1    BLK_DATA offered to LEA core
// BLK_READY  in   1    LEA core accepts block
// CT_VALID   in   1    1-cycle strobe: CT_DATA holds ciphertext
// CT_DATA    in   128  ciphertext words {W3,W2,W1,W0}, same packing as BLK_DATA
// CT_BYTES   out  128  ciphertext bytes for the LCD, same byte order as PT_BYTES
// BUSY       out  1    high in LOAD, SEND, WAIT_CT
// DONE       out  1    high in SHOW (CT_BYTES valid)
// ERR        out  1    high in FAULT (timeout)
// BEHAVIOUR
// - Reset: state=IDLE; BLK_DATA=0, BLK_VALID=0, CT_BYTES=0, BUSY=0, DONE=0, ERR=0, timer=0, sync flops=0.
// - SHARP/STAR pass through SYNC_STAGES flops; a 1-cycle rising-edge pulse (sh_p/st_p) is formed after sync.
//   A held key yields exactly one pulse.
// - Outputs are registered; all latencies below are counted from the cycle a condition is sampled.
// - FSM:
//   IDLE:    sh_p -> LOAD. st_p -> stay IDLE.
//   LOAD:    1 cycle; BLK_DATA <= packed PT_BYTES (snapshot; later PT_BYTES changes ignored) -> SEND.
//   SEND:    BLK_VALID=1. BLK_DATA stable while BLK_VALID && !BLK_READY.
//            On BLK_VALID && BLK_READY: BLK_VALID<=0, timer<=0 -> WAIT_CT.
//   WAIT_CT: timer++ each cycle.
//            CT_VALID -> CT_BYTES <= unpacked CT_DATA -> SHOW.
//            timer==TIMEOUT-1 without CT_VALID -> FAULT.
//   SHOW:    DONE=1; CT_BYTES held. sh_p -> LOAD (re-encrypt current PT_BYTES). st_p -> IDLE, CT_BYTES<=0.
//   FAULT:   ERR=1. st_p or sh_p -> IDLE, ERR<=0.
// - st_p in LOAD/SEND/WAIT_CT: abort -> IDLE, BLK_VALID<=0 the next cycle.
//   A later CT_VALID is ignored in IDLE.
// - Simultaneous sh_p and st_p: st_p wins in every state.
// - CT_VALID arriving on the same cycle the timeout expires is accepted -> SHOW, not FAULT.
// - CT_VALID outside WAIT_CT is ignored. BLK_READY outside SEND is ignored.
// - Pack/unpack is pure byte wiring: W0[7:0]=byte1, W0[31:24]=byte4, W3[31:24]=byte16; unpack is the exact inverse.
// - Timer width is clog2(TIMEOUT) bits minimum; it never wraps inside WAIT_CT.
// - Async reset mid-operation returns to the reset values immediately; no pending handshake survives.
// TESTING
// - PT bytes 0x30..0x3F, '#' held 10 cycles, READY=1 -> one BLK_VALID pulse;
//   BLK_DATA = 3F3E3D3C_3B3A3938_37363534_33323130.
// - READY held low 20 cycles in SEND -> BLK_VALID and BLK_DATA stable all 20 cycles; handshake completes on the first READY.
// - CT_VALID with CT_DATA = 0F0E0D0C_0B0A0908_07060504_03020100 -> CT_BYTES = 00010203..0E0F, DONE=1, BUSY=0.
// - No CT_VALID, TIMEOUT=16 -> ERR=1 exactly 16 cycles after the handshake; '*' -> IDLE, ERR=0.
// - '*' during WAIT_CT, then a CT_VALID -> state IDLE, CT_BYTES=0, DONE=0.
// - '#' and '*' rising on the same cycle in SHOW -> IDLE. RST low mid-SEND -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/lea_block_loader.sv
// Plaintext snapshot / LEA block handshake / ciphertext unpack controller.
// Keys are synchronised and edge-detected; a timeout guards the wait for ciphertext.
module lea_block_loader #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned TIMEOUT     = 4096
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [127:0] pt_bytes_i,
    input  logic         sharp_i,
    input  logic         star_i,
    output logic [127:0] blk_data_o,
    output logic         blk_valid_o,
    input  logic         blk_ready_i,
    input  logic         ct_valid_i,
    input  logic [127:0] ct_data_i,
    output logic [127:0] ct_bytes_o,
    output logic         busy_o,
    output logic         done_o,
    output logic         err_o
);

    localparam int unsigned BLK_W  = 128;
    localparam int unsigned NBYTES = 16;
    localparam int unsigned TMR_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_SEND, S_WAIT_CT, S_SHOW, S_FAULT
    } state_e;

    // Byte order reversal: keyed byte n lands in LEA word byte lane n-1, and back.
    function automatic logic [BLK_W-1:0] byte_rev(input logic [BLK_W-1:0] v);
        logic [BLK_W-1:0] r;
        r = '0;
        for (int i = 0; i < NBYTES; i++) begin
            r[8*i +: 8] = v[8*(NBYTES-1-i) +: 8];
        end
        return r;
    endfunction

    state_e             state_q, state_d;
    logic [SYNC_STAGES-1:0] sh_sync_q, st_sync_q;
    logic               sh_prev_q, st_prev_q;
    logic               sh_p, st_p;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic [BLK_W-1:0]   blk_data_q, blk_data_d;
    logic [BLK_W-1:0]   ct_bytes_q, ct_bytes_d;
    logic               blk_valid_q, busy_q, done_q, err_q;
    logic               blk_valid_d, busy_d, done_d, err_d;

    assign sh_p = sh_sync_q[SYNC_STAGES-1] & ~sh_prev_q;
    assign st_p = st_sync_q[SYNC_STAGES-1] & ~st_prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_sync_q <= '0;
            st_sync_q <= '0;
            sh_prev_q <= 1'b0;
            st_prev_q <= 1'b0;
        end else begin
            sh_sync_q <= {sh_sync_q[SYNC_STAGES-2:0], sharp_i};
            st_sync_q <= {st_sync_q[SYNC_STAGES-2:0], star_i};
            sh_prev_q <= sh_sync_q[SYNC_STAGES-1];
            st_prev_q <= st_sync_q[SYNC_STAGES-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Abort (st_p) has priority over every other transition.
    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        blk_data_d = blk_data_q;
        ct_bytes_d = ct_bytes_q;
        unique case (state_q)
            S_IDLE: begin
                if (!st_p && sh_p) state_d = S_LOAD;
            end
            S_LOAD: begin
                if (st_p) begin
                    state_d = S_IDLE;
                end else begin
                    blk_data_d = byte_rev(pt_bytes_i);
                    state_d    = S_SEND;
                end
            end
            S_SEND: begin
                if (st_p) begin
                    state_d = S_IDLE;
                end else if (blk_ready_i) begin
                    timer_d = '0;
                    state_d = S_WAIT_CT;
                end
            end
            S_WAIT_CT: begin
                if (st_p) begin
                    state_d = S_IDLE;
                end else if (ct_valid_i) begin
                    ct_bytes_d = byte_rev(ct_data_i);
                    state_d    = S_SHOW;
                end else if (timer_q == TMR_W'(TIMEOUT - 1)) begin
                    state_d = S_FAULT;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            S_SHOW: begin
                if (st_p) begin
                    ct_bytes_d = '0;
                    state_d    = S_IDLE;
                end else if (sh_p) begin
                    state_d = S_LOAD;
                end
            end
            S_FAULT: begin
                if (st_p || sh_p) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        blk_valid_d = (state_d == S_SEND);
        busy_d      = (state_d == S_LOAD) || (state_d == S_SEND) || (state_d == S_WAIT_CT);
        done_d      = (state_d == S_SHOW);
        err_d       = (state_d == S_FAULT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer_q     <= '0;
            blk_data_q  <= '0;
            ct_bytes_q  <= '0;
            blk_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            timer_q     <= timer_d;
            blk_data_q  <= blk_data_d;
            ct_bytes_q  <= ct_bytes_d;
            blk_valid_q <= blk_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign blk_data_o  = blk_data_q;
    assign blk_valid_o = blk_valid_q;
    assign ct_bytes_o  = ct_bytes_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign err_o       = err_q;

endmodule
